// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter in front of a single-port synchronous memory. Each port
//   issues one command (read or write) at a time; the arbiter grants one of
//   them, drives a one-cycle memory strobe, and for reads captures the memory
//   data one cycle later and returns it on the shared RDATA bus together with
//   a per-port RVALID pulse.
//
//   Configuration macro:
//     ARB_FIXED_PRIORITY_EN  - when defined, port 0 always wins a tie and the
//                              LAST pointer is held at 1. When undefined the
//                              arbiter is round-robin on the LAST pointer.
//
//   Ports:
//     CLK, RESET              clock (rising edge), synchronous active-high reset
//     REQn/WEn/ADDRn/WDATAn   requester n command (n = 0, 1)
//     GNTn                    one-cycle pulse: command of port n accepted
//     RVALIDn                 one-cycle pulse: RDATA holds port n's read result
//     RDATA                   shared read data (held until the next capture)
//     BUSY                    high whenever the FSM is not in IDLE
//     MEM_ADDR/MEM_WDATA      memory address / write data
//     MEM_WE/MEM_RE           one-cycle memory write / read strobes
//     MEM_RDATA               memory read data, valid the cycle after MEM_RE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ0,
    input  logic          WE0,
    input  logic [AW-1:0] ADDR0,
    input  logic [DW-1:0] WDATA0,
    output logic          GNT0,
    output logic          RVALID0,
    input  logic          REQ1,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA1,
    output logic          GNT1,
    output logic          RVALID1,
    output logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    output logic          MEM_WE,
    output logic          MEM_RE,
    input  logic [DW-1:0] MEM_RDATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        CAPT   = 2'd2
    } state_t;

    state_t        state_r, state_next_s;
    logic          last_r, last_next_s;       // last granted port
    logic          win_r, win_next_s;         // port currently being served
    logic          we_cmd_r, we_cmd_next_s;   // latched command type
    logic          gnt0_r, gnt0_next_s;
    logic          gnt1_r, gnt1_next_s;
    logic          rvalid0_r, rvalid0_next_s;
    logic          rvalid1_r, rvalid1_next_s;
    logic          mem_we_r, mem_we_next_s;
    logic          mem_re_r, mem_re_next_s;
    logic          busy_r, busy_next_s;
    logic [AW-1:0] mem_addr_r, mem_addr_next_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_next_s;
    logic [DW-1:0] rdata_r, rdata_next_s;
    logic          arb_win_s;                 // arbitration result for this edge

    // Arbitration: choose the winning port from the current requests.
`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        arb_win_s = 1'b0;
        if (REQ0) begin
            arb_win_s = 1'b0;
        end else begin
            arb_win_s = 1'b1;
        end
    end
`else
    always_comb begin
        arb_win_s = 1'b0;
        if (REQ0 && REQ1) begin
            // Tie: the port that did not win last time goes next.
            arb_win_s = ~last_r;
        end else if (REQ0) begin
            arb_win_s = 1'b0;
        end else begin
            arb_win_s = 1'b1;
        end
    end
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next_s     = state_r;
        last_next_s      = last_r;
        win_next_s       = win_r;
        we_cmd_next_s    = we_cmd_r;
        gnt0_next_s      = 1'b0;
        gnt1_next_s      = 1'b0;
        rvalid0_next_s   = 1'b0;
        rvalid1_next_s   = 1'b0;
        mem_we_next_s    = 1'b0;
        mem_re_next_s    = 1'b0;
        mem_addr_next_s  = mem_addr_r;
        mem_wdata_next_s = mem_wdata_r;
        rdata_next_s     = rdata_r;

        case (state_r)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    state_next_s = ACCESS;
                    win_next_s   = arb_win_s;
                    if (arb_win_s == 1'b0) begin
                        mem_addr_next_s  = ADDR0;
                        mem_wdata_next_s = WDATA0;
                        we_cmd_next_s    = WE0;
                        gnt0_next_s      = 1'b1;
                    end else begin
                        mem_addr_next_s  = ADDR1;
                        mem_wdata_next_s = WDATA1;
                        we_cmd_next_s    = WE1;
                        gnt1_next_s      = 1'b1;
                    end
                    mem_we_next_s = we_cmd_next_s;
                    mem_re_next_s = ~we_cmd_next_s;
`ifdef ARB_FIXED_PRIORITY_EN
                    last_next_s   = 1'b1;
`else
                    last_next_s   = arb_win_s;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                // The strobe was on the bus this cycle; a read needs one more
                // cycle for the memory data to appear.
                if (we_cmd_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = CAPT;
                end
            end
            CAPT: begin
                rdata_next_s = MEM_RDATA;
                if (win_r) begin
                    rvalid1_next_s = 1'b1;
                end else begin
                    rvalid0_next_s = 1'b1;
                end
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        busy_next_s = (state_next_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            win_r       <= 1'b0;
            we_cmd_r    <= 1'b0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            rvalid0_r   <= 1'b0;
            rvalid1_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            busy_r      <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            rdata_r     <= {DW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            last_r      <= last_next_s;
            win_r       <= win_next_s;
            we_cmd_r    <= we_cmd_next_s;
            gnt0_r      <= gnt0_next_s;
            gnt1_r      <= gnt1_next_s;
            rvalid0_r   <= rvalid0_next_s;
            rvalid1_r   <= rvalid1_next_s;
            mem_we_r    <= mem_we_next_s;
            mem_re_r    <= mem_re_next_s;
            busy_r      <= busy_next_s;
            mem_addr_r  <= mem_addr_next_s;
            mem_wdata_r <= mem_wdata_next_s;
            rdata_r     <= rdata_next_s;
        end
    end

    assign GNT0      = gnt0_r;
    assign GNT1      = gnt1_r;
    assign RVALID0   = rvalid0_r;
    assign RVALID1   = rvalid1_r;
    assign RDATA     = rdata_r;
    assign BUSY      = busy_r;
    assign MEM_ADDR  = mem_addr_r;
    assign MEM_WDATA = mem_wdata_r;
    assign MEM_WE    = mem_we_r;
    assign MEM_RE    = mem_re_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A driver issues per-port commands
//   (directed sequences and $urandom traffic) and a transaction-level reference
//   model predicts, for every sampling edge, which port is granted, when, with
//   which address/data, and what each read returns. Predictions go into queues;
//   a monitor on the falling edge pops and compares whenever the DUT pulses
//   GNT or RVALID. A simple memory responder answers the DUT's strobes.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          REQ0, WE0, REQ1, WE1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          GNT0, GNT1, RVALID0, RVALID1, BUSY, MEM_WE, MEM_RE;
    logic [DW-1:0] RDATA, MEM_WDATA, MEM_RDATA;
    logic [AW-1:0] MEM_ADDR;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
        .GNT0(GNT0), .RVALID0(RVALID0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1),
        .GNT1(GNT1), .RVALID1(RVALID1),
        .RDATA(RDATA), .BUSY(BUSY),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory responder: acts on the DUT's strobes, read data one cycle later.
    logic [DW-1:0] mem [16] = '{default: 8'h00};
    logic [DW-1:0] mem_rdata_q = 8'h00;
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
        if (MEM_RE) mem_rdata_q <= mem[MEM_ADDR];
    end
    assign MEM_RDATA = mem_rdata_q;

    // Expected-response records.
    typedef struct {
        int            cyc;
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t gq[$];   // expected grants
    exp_t rq[$];   // expected read returns

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state (transaction level).
    logic [DW-1:0] ref_mem [16] = '{default: 8'h00};
    bit            last  = 1'b1;
    int            mbusy = 0;     // sampling edges still to be ignored
    bit            pend [2];
    bit            cwe  [2];
    logic [AW-1:0] caddr[2];
    logic [DW-1:0] cdata[2];

    task automatic new_cmd(input int n, input bit force_read);
        cwe[n]   = force_read ? 1'b0 : 1'($urandom_range(0, 1));
        caddr[n] = AW'($urandom_range(0, 15));
        cdata[n] = DW'($urandom_range(0, 255));
        pend[n]  = 1'b1;
    endtask

    task automatic set_cmd(input int n, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cwe[n] = we; caddr[n] = a; cdata[n] = d; pend[n] = 1'b1;
    endtask

    // One cycle: drive inputs for the coming edge and predict its outcome.
    // mode 0 = hold current commands, 1 = random traffic, 2 = saturating reads.
    task automatic step(input int mode, input bit rst);
        exp_t e;
        bit   w;
        @(negedge CLK);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (mode == 1) begin
                if (!pend[n] && $urandom_range(0, 2) == 0) new_cmd(n, 1'b0);
                else if (pend[n] && $urandom_range(0, 15) == 0) pend[n] = 1'b0;
            end else if (mode == 2) begin
                if (!pend[n]) new_cmd(n, 1'b1);
            end
        end
        RESET  = rst;
        REQ0   = pend[0]; WE0 = cwe[0]; ADDR0 = caddr[0]; WDATA0 = cdata[0];
        REQ1   = pend[1]; WE1 = cwe[1]; ADDR1 = caddr[1]; WDATA1 = cdata[1];
        if (rst) begin
            gq.delete();
            rq.delete();
            mbusy = 0;
            last  = 1'b1;
        end else if (mbusy > 0) begin
            mbusy--;
        end else if (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) w = FIXED ? 1'b0 : !last;
            else                    w = pend[0] ? 1'b0 : 1'b1;
            e.cyc = cyc + 1; e.port = w; e.we = cwe[w]; e.addr = caddr[w]; e.data = cdata[w];
            gq.push_back(e);
            if (cwe[w]) begin
                ref_mem[caddr[w]] = cdata[w];
                mbusy = 1;
            end else begin
                e.cyc = cyc + 3; e.data = ref_mem[caddr[w]];
                rq.push_back(e);
                mbusy = 2;
            end
            last    = FIXED ? 1'b1 : w;
            pend[w] = 1'b0;
        end
    endtask

    // Monitor: compare DUT pulses against the predicted queues.
    exp_t me;
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("gnt_excl",    32'(GNT0 & GNT1), 32'd0);
            chk("rvalid_excl", 32'(RVALID0 & RVALID1), 32'd0);
            chk("strobe_excl", 32'(MEM_WE & MEM_RE), 32'd0);
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                chk("gnt_missing", 32'(cyc), 32'(gq[0].cyc));
                void'(gq.pop_front());
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("rvalid_missing", 32'(cyc), 32'(rq[0].cyc));
                void'(rq.pop_front());
            end
            if (GNT0 || GNT1) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 32'({GNT1, GNT0}), 32'd0);
                end else begin
                    me = gq.pop_front();
                    chk("gnt_cycle", 32'(cyc), 32'(me.cyc));
                    chk("gnt_port",  32'({GNT1, GNT0}), me.port ? 32'd2 : 32'd1);
                    chk("mem_addr",  32'(MEM_ADDR), 32'(me.addr));
                    chk("mem_we",    32'(MEM_WE), 32'(me.we));
                    chk("mem_re",    32'(MEM_RE), 32'(!me.we));
                    if (me.we) chk("mem_wdata", 32'(MEM_WDATA), 32'(me.data));
                    chk("busy_on_gnt", 32'(BUSY), 32'd1);
                end
            end else begin
                chk("stray_strobe", 32'(MEM_WE | MEM_RE), 32'd0);
            end
            if (RVALID0 || RVALID1) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", 32'({RVALID1, RVALID0}), 32'd0);
                end else begin
                    me = rq.pop_front();
                    chk("rvalid_cycle", 32'(cyc), 32'(me.cyc));
                    chk("rvalid_port",  32'({RVALID1, RVALID0}), me.port ? 32'd2 : 32'd1);
                    chk("rdata",        32'(RDATA), 32'(me.data));
                    chk("busy_on_rvalid", 32'(BUSY), 32'd0);
                end
            end
        end
    end

    initial begin
        RESET = 1'b1;
        REQ0 = 1'b0; WE0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
        REQ1 = 1'b0; WE1 = 1'b0; ADDR1 = '0; WDATA1 = '0;
        for (int n = 0; n < 2; n++) begin
            pend[n] = 1'b0; cwe[n] = 1'b0; caddr[n] = '0; cdata[n] = '0;
        end

        // Reset values
        step(0, 1'b1);
        step(0, 1'b1);
        step(0, 1'b0);
        chk("rst_gnt",    32'({GNT1, GNT0}), 32'd0);
        chk("rst_rvalid", 32'({RVALID1, RVALID0}), 32'd0);
        chk("rst_strobe", 32'({MEM_WE, MEM_RE}), 32'd0);
        chk("rst_busy",   32'(BUSY), 32'd0);
        chk("rst_rdata",  32'(RDATA), 32'd0);
        chk("rst_addr",   32'(MEM_ADDR), 32'd0);
        chk("rst_wdata",  32'(MEM_WDATA), 32'd0);
        mon_en = 1'b1;

        // Single requester on port 1 right after reset (LAST = 1)
        set_cmd(1, 1'b0, 4'd7, 8'h00);
        repeat (5) step(0, 1'b0);

        // Port 0 write 0xA5 to address 3, then read it back
        set_cmd(0, 1'b1, 4'd3, 8'hA5);
        repeat (3) step(0, 1'b0);
        set_cmd(0, 1'b0, 4'd3, 8'h00);
        repeat (4) step(0, 1'b0);

        // Back-to-back: port 1 write presented in the RVALID0 cycle
        set_cmd(0, 1'b0, 4'd3, 8'h00);
        repeat (3) step(0, 1'b0);
        set_cmd(1, 1'b1, 4'd15, 8'hFF);
        repeat (4) step(0, 1'b0);

        // Withdrawal: one-cycle REQ1 while port 0 is being served
        set_cmd(0, 1'b0, 4'd5, 8'h00);
        step(0, 1'b0);
        set_cmd(1, 1'b1, 4'd9, 8'h3C);
        step(0, 1'b0);
        pend[1] = 1'b0;
        repeat (5) step(0, 1'b0);

        // Contention: both ports continuously requesting reads
        repeat (12) step(2, 1'b0);
        repeat (10) step(0, 1'b0);

        // Random traffic
        repeat (600) step(1, 1'b0);
        repeat (10) step(0, 1'b0);

        // Reset while the read is in CAPT
        set_cmd(0, 1'b0, 4'd3, 8'h00);
        step(0, 1'b0);
        step(0, 1'b0);
        step(0, 1'b1);
        step(0, 1'b0);
        chk("rstcapt_rvalid", 32'({RVALID1, RVALID0}), 32'd0);
        chk("rstcapt_rdata",  32'(RDATA), 32'd0);
        chk("rstcapt_busy",   32'(BUSY), 32'd0);
        repeat (4) step(0, 1'b0);

        chk("gnt_queue_empty",    32'(gq.size()), 32'd0);
        chk("rvalid_queue_empty", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 4: address width (16 locations).
REQ-002 SHALL have parameter DW, default 8: data width.
REQ-003 SHALL use one clock and a synchronous, active-high reset, named as follows.
- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
REQ-004 SHALL have the requester ports below (n = 0, 1).
- REQn  in  1  access request; held high until GNTn.
- WEn  in  1  1 = write, 0 = read; stable while REQn is high.
- ADDRn  in  AW  access address; stable while REQn is high.
- WDATAn  in  DW  write data; stable while REQn is high.
- GNTn  out  1  one-cycle pulse; the command was accepted.
- RVALIDn  out  1  one-cycle pulse; RDATA holds the read result for port n.
REQ-005 SHALL have the shared and memory-side ports below.
- RDATA  out  DW  read data, shared by both ports.
- BUSY  out  1  high whenever the state is not IDLE.
- MEM_ADDR  out  AW  memory address.
- MEM_WDATA  out  DW  memory write data.
- MEM_WE  out  1  memory write strobe, one cycle.
- MEM_RE  out  1  memory read strobe, one cycle.
- MEM_RDATA  in  DW  memory read data, valid the cycle after MEM_RE.

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS, CAPT; the reset state is IDLE.
REQ-007 In IDLE, if any REQn is high at an edge, SHALL at that edge:
- pick a winner;
- register its ADDR/WDATA/WE into MEM_ADDR/MEM_WDATA;
- drive GNTwinner=1 and either MEM_WE=1 (write) or MEM_RE=1 (read) for the next cycle;
- enter ACCESS.
REQ-008 If no REQ is high in IDLE, SHALL stay in IDLE with all strobes low.
REQ-009 From ACCESS, SHALL go to IDLE after a write and to CAPT after a read.
REQ-010 In CAPT, SHALL register MEM_RDATA into RDATA, pulse RVALIDwinner for the following cycle, and return to IDLE.
REQ-011 Latency: with REQ sampled at edge k, GNT and the strobe SHALL be high in cycle k+1, and a read's RVALID SHALL be high in cycle k+3.
REQ-012 Throughput: SHALL sustain one write per 2 cycles and one read per 3 cycles; a new request may be sampled in the same IDLE cycle in which RVALID is high.
REQ-013 Arbitration (default) SHALL be round-robin. A 1-bit LAST pointer records the last winner. With both REQ high, SHALL grant the port not equal to LAST; with a single REQ, SHALL grant it regardless of LAST.
REQ-014 LAST SHALL update only on a grant.
REQ-015 A REQn deasserted before its grant SHALL be withdrawn with no side effect.
REQ-016 REQ/command changes while BUSY SHALL be ignored until the next IDLE sampling edge.
REQ-017 GNT0/GNT1, RVALID0/RVALID1 and MEM_WE/MEM_RE SHALL each be mutually exclusive, and never high simultaneously with each other.
REQ-018 RDATA SHALL hold its value until the next CAPT.
REQ-019 Address wrap SHALL NOT occur; addresses pass through unmodified at AW width.

Reset
REQ-020 On RESET=1 at an edge, SHALL set state=IDLE, LAST=1 (port 0 wins the first tie), and all outputs to 0, including RDATA, MEM_ADDR and MEM_WDATA.
REQ-021 Reset mid-operation (ACCESS or CAPT) SHALL abort the access: no GNT, RVALID or strobe pulse in the cycle after reset.
REQ-022 RESET SHALL take priority over all requests.

Configuration
REQ-023 With macro ARB_FIXED_PRIORITY_EN defined, SHALL use fixed priority: port 0 always wins when both REQ are high, and LAST is unused (held 1). Without the macro, round-robin per REQ-013 applies.

Verification
REQ-024 Write then read, port 0: REQ0, WE0=1, ADDR0=3, WDATA0=0xA5 -> GNT0 and MEM_WE high one cycle later with MEM_ADDR=3 and MEM_WDATA=0xA5. Then a read of ADDR0=3 with the memory model returning 0xA5 -> RVALID0 at k+3 with RDATA=0xA5.
REQ-025 Contention: REQ0 and REQ1 held high for 4 reads -> grant order 0,1,0,1 (round-robin). With ARB_FIXED_PRIORITY_EN -> 0,0,0,0 while REQ0 stays high.
REQ-026 Single requester: REQ1 alone with LAST=1 -> GNT1 is granted; no GNT0 pulse.
REQ-027 Reset mid-read: RESET during CAPT -> RVALID0/RVALID1 stay 0, RDATA=0x00, BUSY=0 on the next cycle.
REQ-028 Withdrawal: REQ1 pulsed for one cycle while BUSY serving port 0 -> no GNT1, with MEM_ADDR showing only port 0's address.
REQ-029 Back-to-back: read on port 0, then REQ1 write (ADDR1=15, WDATA1=0xFF) presented during the RVALID0 cycle -> GNT1 in the next cycle with MEM_ADDR=15.
